player_bullet: RTL and testbench

//  Player projectile: launches from the player ship on fire_i and climbs one step per frame_i.

---
 rtl/space_invaders_pkg.sv | 21 ++
 rtl/bullet_collide.sv | 48 ++++
 rtl/pos_counter.sv | 38 +++
 rtl/player_bullet.sv | 167 ++++++++++++++++
 tb/tb_player_bullet.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/space_invaders_pkg.sv
// Shared types and constants for the space invaders blocks.
// Screen geometry, the bullet FSM encoding and a saturating subtract helper.
package space_invaders_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    typedef logic [9:0] pos_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'b001,
        ST_FLYING = 3'b010,
        ST_IMPACT = 3'b100
    } bullet_state_e;

    // Clamps at zero so screen coordinates never wrap.
    function automatic pos_t sat_sub(input pos_t a, input pos_t b);
        return (a >= b) ? pos_t'(a - b) : '0;
    endfunction

endpackage

// File: rtl/bullet_collide.sv
// Combinational bullet/enemy box overlap with dead masking.
// The lowest-index live overlapping enemy wins; result is one-hot.
module bullet_collide
    import space_invaders_pkg::*;
#(
    parameter int num_enemies_p = 8
) (
    input  pos_t                      bl_i,
    input  pos_t                      br_i,
    input  pos_t                      bt_i,
    input  pos_t                      bb_i,
    input  logic [10*num_enemies_p-1:0] enemy_left_i,
    input  logic [10*num_enemies_p-1:0] enemy_right_i,
    input  logic [10*num_enemies_p-1:0] enemy_top_i,
    input  logic [10*num_enemies_p-1:0] enemy_bot_i,
    input  logic [num_enemies_p-1:0]  enemy_dead_i,
    output logic [num_enemies_p-1:0]  hit_onehot_o,
    output logic                      any_hit_o
);

    logic [num_enemies_p-1:0] overlap;
    logic                     found;

    // Inclusive, unsigned box test on every enemy slot.
    always_comb begin
        overlap = '0;
        for (int k = 0; k < num_enemies_p; k++) begin
            overlap[k] = !enemy_dead_i[k]
                      && (bl_i <= enemy_right_i[10*k +: 10])
                      && (br_i >= enemy_left_i[10*k +: 10])
                      && (bt_i <= enemy_bot_i[10*k +: 10])
                      && (bb_i >= enemy_top_i[10*k +: 10]);
        end
    end

    always_comb begin
        hit_onehot_o = '0;
        found        = 1'b0;
        for (int k = 0; k < num_enemies_p; k++) begin
            if (overlap[k] && !found) begin
                hit_onehot_o[k] = 1'b1;
                found           = 1'b1;
            end
        end
        any_hit_o = found;
    end

endmodule

// File: rtl/pos_counter.sv
// Shared position counter: load a start value, or step down by step_p.
// Stepping saturates at zero.
module pos_counter
    import space_invaders_pkg::*;
#(
    parameter pos_t step_p = 10'd4
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic load_i,
    input  pos_t load_val_i,
    input  logic down_i,
    output pos_t count_o
);

    pos_t count_q;
    pos_t count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (down_i) begin
            count_d = sat_sub(count_q, step_p);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/player_bullet.sv
// Player projectile: launches from the ship on fire_i, climbs per frame_i,
// and reports a one-hot hit to the struck enemy or a miss at the top limit.
module player_bullet
    import space_invaders_pkg::*;
#(
    parameter int   num_enemies_p = 8,
    parameter pos_t bullet_w_p    = 10'd2,
    parameter pos_t bullet_h_p    = 10'd8,
    parameter pos_t speed_p       = 10'd4,
    parameter pos_t top_limit_p   = 10'd0
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        frame_i,
    input  logic                        fire_i,
    input  pos_t                        player_left_i,
    input  pos_t                        player_right_i,
    input  pos_t                        player_top_i,
    input  logic [10*num_enemies_p-1:0] enemy_left_i,
    input  logic [10*num_enemies_p-1:0] enemy_right_i,
    input  logic [10*num_enemies_p-1:0] enemy_top_i,
    input  logic [10*num_enemies_p-1:0] enemy_bot_i,
    input  logic [num_enemies_p-1:0]    enemy_dead_i,
    output pos_t                        left_pos_o,
    output pos_t                        right_pos_o,
    output pos_t                        top_pos_o,
    output pos_t                        bot_pos_o,
    output logic                        active_o,
    output logic [num_enemies_p-1:0]    hit_o,
    output logic                        miss_o,
    output bullet_state_e               dbg_state_o
);

    // Handshake: fire_i is the request (valid); the bullet is ready only in
    // ST_IDLE, so a request seen in any other state is dropped, never queued.

    bullet_state_e            state_q, state_d;
    pos_t                     left_q, left_d;
    pos_t                     right_q, right_d;
    pos_t                     bot_q, bot_d;
    logic [num_enemies_p-1:0] hit_q, hit_d;
    logic                     miss_q, miss_d;
    logic                     active_q, active_d;

    pos_t                     top_cnt;
    logic                     top_load;
    logic                     top_down;
    logic [10:0]              player_sum;
    pos_t                     launch_left;
    pos_t                     launch_top;
    logic                     past_limit;
    logic [num_enemies_p-1:0] col_onehot;
    logic                     col_any;

    assign player_sum  = {1'b0, player_left_i} + {1'b0, player_right_i};
    assign launch_left = sat_sub(player_sum[10:1], bullet_w_p >> 1);
    assign launch_top  = sat_sub(player_top_i, bullet_h_p);
    // Widened compare so a large top_limit_p + speed_p cannot wrap.
    assign past_limit  = {1'b0, top_cnt} < ({1'b0, top_limit_p} + {1'b0, speed_p});

    pos_counter #(
        .step_p (speed_p)
    ) u_top_cnt (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .load_i     (top_load),
        .load_val_i (launch_top),
        .down_i     (top_down),
        .count_o    (top_cnt)
    );

    bullet_collide #(
        .num_enemies_p (num_enemies_p)
    ) u_collide (
        .bl_i          (left_q),
        .br_i          (right_q),
        .bt_i          (top_cnt),
        .bb_i          (bot_q),
        .enemy_left_i  (enemy_left_i),
        .enemy_right_i (enemy_right_i),
        .enemy_top_i   (enemy_top_i),
        .enemy_bot_i   (enemy_bot_i),
        .enemy_dead_i  (enemy_dead_i),
        .hit_onehot_o  (col_onehot),
        .any_hit_o     (col_any)
    );

    always_comb begin
        state_d  = state_q;
        left_d   = left_q;
        right_d  = right_q;
        bot_d    = bot_q;
        hit_d    = '0;
        miss_d   = 1'b0;
        active_d = active_q;
        top_load = 1'b0;
        top_down = 1'b0;
        case (state_q)
            ST_IDLE: begin
                active_d = 1'b0;
                if (fire_i) begin
                    state_d  = ST_FLYING;
                    active_d = 1'b1;
                    left_d   = launch_left;
                    right_d  = launch_left + bullet_w_p - 10'd1;
                    bot_d    = launch_top + bullet_h_p - 10'd1;
                    top_load = 1'b1;
                end
            end
            ST_FLYING: begin
                // Collision is judged on the box before this frame's move.
                if (frame_i) begin
                    if (col_any) begin
                        state_d  = ST_IMPACT;
                        hit_d    = col_onehot;
                        active_d = 1'b0;
                    end else if (past_limit) begin
                        state_d  = ST_IDLE;
                        miss_d   = 1'b1;
                        active_d = 1'b0;
                    end else begin
                        top_down = 1'b1;
                        bot_d    = bot_q - speed_p;
                    end
                end
            end
            ST_IMPACT: begin
                state_d  = ST_IDLE;
                active_d = 1'b0;
            end
            default: begin
                state_d  = ST_IDLE;
                active_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= ST_IDLE;
            left_q   <= '0;
            right_q  <= '0;
            bot_q    <= '0;
            hit_q    <= '0;
            miss_q   <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            left_q   <= left_d;
            right_q  <= right_d;
            bot_q    <= bot_d;
            hit_q    <= hit_d;
            miss_q   <= miss_d;
            active_q <= active_d;
        end
    end

    assign left_pos_o  = left_q;
    assign right_pos_o = right_q;
    assign top_pos_o   = top_cnt;
    assign bot_pos_o   = bot_q;
    assign active_o    = active_q;
    assign hit_o       = hit_q;
    assign miss_o      = miss_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_player_bullet.sv
// Directed bench for player_bullet: launch, hit, priority/dead masking,
// miss at the top edge, fire held through flight, and reset mid-flight.
module tb_player_bullet;
    import space_invaders_pkg::*;

    localparam int N = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          frame = 1'b0;
    logic          fire = 1'b0;
    pos_t          pl, pr, pt;
    logic [10*N-1:0] el, er, et, eb;
    logic [N-1:0]  dead;
    pos_t          left_pos, right_pos, top_pos, bot_pos;
    logic          active, miss;
    logic [N-1:0]  hit;
    bullet_state_e state;

    int checks = 0;
    int errors = 0;

    player_bullet dut (
        .clk_i          (clk),
        .reset_i        (reset),
        .frame_i        (frame),
        .fire_i         (fire),
        .player_left_i  (pl),
        .player_right_i (pr),
        .player_top_i   (pt),
        .enemy_left_i   (el),
        .enemy_right_i  (er),
        .enemy_top_i    (et),
        .enemy_bot_i    (eb),
        .enemy_dead_i   (dead),
        .left_pos_o     (left_pos),
        .right_pos_o    (right_pos),
        .top_pos_o      (top_pos),
        .bot_pos_o      (bot_pos),
        .active_o       (active),
        .hit_o          (hit),
        .miss_o         (miss),
        .dbg_state_o    (state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // One frame tick; outputs of that frame are visible on return.
    task automatic do_frame();
        frame = 1'b1;
        tick();
        frame = 1'b0;
    endtask

    task automatic set_enemy(input int k, input pos_t l, input pos_t r, input pos_t t, input pos_t b);
        el[10*k +: 10] = l;
        er[10*k +: 10] = r;
        et[10*k +: 10] = t;
        eb[10*k +: 10] = b;
    endtask

    task automatic park_all();
        for (int k = 0; k < N; k++) set_enemy(k, 10'd0, 10'd5, 10'd0, 10'd5);
    endtask

    initial begin
        pl = 10'd300;
        pr = 10'd316;
        pt = 10'd440;
        dead = '0;
        park_all();

        // Reset state
        tick();
        tick();
        reset = 1'b0;
        chk("rst_active", active, 0);
        chk("rst_hit", hit, 0);
        chk("rst_miss", miss, 0);
        chk("rst_left", left_pos, 0);
        chk("rst_top", top_pos, 0);
        chk("rst_state", state, 3'b001);

        // 1 Launch, with a simultaneous frame that must not move the bullet
        fire = 1'b1;
        frame = 1'b1;
        tick();
        fire = 1'b0;
        frame = 1'b0;
        chk("launch_active", active, 1);
        chk("launch_left", left_pos, 307);
        chk("launch_right", right_pos, 308);
        chk("launch_top", top_pos, 432);
        chk("launch_bot", bot_pos, 439);
        chk("launch_state", state, 3'b010);

        // 2 Hit on enemy 0 at the 7th frame
        set_enemy(0, 10'd305, 10'd315, 10'd400, 10'd410);
        for (int f = 1; f <= 6; f++) begin
            do_frame();
            chk("fly_top", top_pos, 432 - 4 * f);
            chk("fly_nohit", hit, 0);
        end
        chk("fly_bot", bot_pos, 415);
        do_frame();
        chk("hit0", hit, 8'h01);
        chk("hit0_active", active, 0);
        chk("hit0_miss", miss, 0);
        chk("hit0_state", state, 3'b100);
        chk("hit0_top_hold", top_pos, 408);
        tick();
        chk("hit0_clear", hit, 0);
        chk("hit0_idle", state, 3'b001);
        chk("hold_left", left_pos, 307);

        // 3 Priority between enemies 2 and 5, then dead masking
        park_all();
        set_enemy(2, 10'd305, 10'd315, 10'd400, 10'd410);
        set_enemy(5, 10'd305, 10'd315, 10'd400, 10'd410);
        fire = 1'b1;
        tick();
        fire = 1'b0;
        repeat (7) do_frame();
        chk("prio_hit2", hit, 8'h04);
        tick();
        dead = 8'h04;
        fire = 1'b1;
        tick();
        fire = 1'b0;
        repeat (7) do_frame();
        chk("dead_hit5", hit, 8'h20);
        tick();

        // 4 All dead: no hit, climb to 0, miss on the 109th frame; fire held
        dead = 8'hFF;
        fire = 1'b1;
        tick();
        repeat (7) do_frame();
        chk("alldead_nohit", hit, 0);
        chk("alldead_active", active, 1);
        chk("alldead_top", top_pos, 404);
        repeat (101) do_frame();
        chk("edge_top", top_pos, 0);
        chk("edge_active", active, 1);
        chk("edge_nomiss", miss, 0);
        do_frame();
        chk("miss_pulse", miss, 1);
        chk("miss_nohit", hit, 0);
        chk("miss_active", active, 0);
        chk("miss_state", state, 3'b001);
        chk("miss_top_hold", top_pos, 0);
        tick();
        chk("miss_clear", miss, 0);
        chk("refire_miss_active", active, 1);
        chk("refire_miss_top", top_pos, 432);

        // 5 Fire held through flight is ignored; relaunch after IMPACT
        dead = '0;
        park_all();
        set_enemy(0, 10'd305, 10'd315, 10'd400, 10'd410);
        repeat (6) do_frame();
        chk("held_top", top_pos, 408);
        chk("held_active", active, 1);
        do_frame();
        chk("held_hit", hit, 8'h01);
        tick();
        chk("held_idle_active", active, 0);
        chk("held_idle_state", state, 3'b001);
        tick();
        chk("refire_hit_active", active, 1);
        chk("refire_hit_top", top_pos, 432);

        // 6 Reset mid-flight at top 420
        repeat (3) do_frame();
        chk("pre_rst_top", top_pos, 420);
        fire = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_active", active, 0);
        chk("midrst_hit", hit, 0);
        chk("midrst_miss", miss, 0);
        chk("midrst_left", left_pos, 0);
        chk("midrst_right", right_pos, 0);
        chk("midrst_top", top_pos, 0);
        chk("midrst_bot", bot_pos, 0);
        chk("midrst_state", state, 3'b001);
        do_frame();
        tick();
        chk("post_rst_hit", hit, 0);
        chk("post_rst_miss", miss, 0);
        chk("post_rst_active", active, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
